// File: rtl/rng_pkg.sv
// rng_pkg: shared state encoding, word width and popcount helper for the RNG packer
package rng_pkg;
    localparam int WORD_BITS = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DRAIN} state_t;
    function automatic logic [5:0] popcount(input logic [WORD_BITS-1:0] w);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < WORD_BITS; i++) c = c + 6'(w[i]);
        return c;
    endfunction
endpackage

// File: rtl/rng_word_fifo.sv
// rng_word_fifo: small word buffer with data+last entries and a mark-tail-as-last input
module rng_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             set_last,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW-1:0] tail_idx;
    logic do_push, do_pop;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = wr_ptr == rd_ptr;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign tail_idx = wr_ptr[AW-1:0] - AW'(1);
    assign head     = mem[rd_ptr[AW-1:0]];
    // read/write pointers; the extra MSB separates full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    // entry storage; set_last flags the most recently written entry
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
        if (set_last && !empty) mem[tail_idx][WIDTH-1] <= 1'b1;
    end
endmodule

// File: rtl/rng_stream_packer.sv
// rng_stream_packer: packs entropy bits into 32-bit words and streams them over AXI-Stream
module rng_stream_packer
    import rng_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        BIT_IN,
    input  logic        BIT_VALID,
    input  logic        RNG_GO,
    input  logic        RNG_STOP,
    input  logic [31:0] RNG_SEND_BYTES,
    output logic        RNG_RUN,
    output logic        RNG_OVER,
    output logic [31:0] RNG_SENT_BYTES,
    output logic [31:0] RNG_SUM_DATA,
    output logic [31:0] AXIS_RNG_TDATA,
    output logic        AXIS_RNG_TLAST,
    output logic        AXIS_RNG_TVALID,
    input  logic        AXIS_RNG_TREADY
);
    state_t state, state_nx;
    logic [WORD_BITS-1:0] shreg, word;
    logic [WORD_BITS:0] head;
    logic [4:0] bit_cnt;
    logic [29:0] target, pushed;
    logic full, empty, collecting, word_done, push, push_last, set_last, pop;
    assign collecting      = state == ST_COLLECT;
    assign word            = {shreg[WORD_BITS-2:0], BIT_IN};
    assign word_done       = collecting && BIT_VALID && bit_cnt == 5'd31;
    assign push            = word_done && !full;
    assign push_last       = RNG_STOP || (target != '0 && pushed + 30'd1 == target);
    assign set_last        = collecting && RNG_STOP && !push && !empty;
    assign pop             = AXIS_RNG_TVALID && AXIS_RNG_TREADY;
    assign RNG_RUN         = state != ST_IDLE;
    assign AXIS_RNG_TVALID = !empty;
    assign AXIS_RNG_TDATA  = empty ? '0 : head[WORD_BITS-1:0];
    assign AXIS_RNG_TLAST  = !empty && head[WORD_BITS];

    rng_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_BITS + 1)) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_X),
        .push      (push),
        .push_data ({push_last, word}),
        .pop       (pop),
        .set_last  (set_last),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // state register
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // next state: a last-tagged push or a stop with buffered words drains, a stop on empty idles
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (RNG_GO) state_nx = ST_COLLECT;
            ST_COLLECT: begin
                if ((push && push_last) || (RNG_STOP && !empty)) state_nx = ST_DRAIN;
                else if (RNG_STOP)                                state_nx = ST_IDLE;
            end
            ST_DRAIN:   if (empty) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // shifter, run counters and sticky overrun; GO in idle starts a fresh run
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            shreg          <= '0;
            bit_cnt        <= '0;
            target         <= '0;
            pushed         <= '0;
            RNG_OVER       <= 1'b0;
            RNG_SENT_BYTES <= '0;
            RNG_SUM_DATA   <= '0;
        end else if (state == ST_IDLE && RNG_GO) begin
            shreg          <= '0;
            bit_cnt        <= '0;
            target         <= RNG_SEND_BYTES[31:2];
            pushed         <= '0;
            RNG_OVER       <= 1'b0;
            RNG_SENT_BYTES <= '0;
            RNG_SUM_DATA   <= '0;
        end else begin
            if (collecting && BIT_VALID) begin
                shreg   <= word;
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (push) pushed <= pushed + 30'd1;
            if (word_done && full) RNG_OVER <= 1'b1;
            if (pop) begin
                RNG_SENT_BYTES <= RNG_SENT_BYTES + 32'd4;
                RNG_SUM_DATA   <= RNG_SUM_DATA + 32'(popcount(AXIS_RNG_TDATA));
            end
        end
    end
endmodule

// File: tb/tb_rng_stream_packer.sv
// tb_rng_stream_packer: directed and randomized checks against a queue-based reference model
module tb_rng_stream_packer;
    localparam int DEPTH = 4;
    logic        CLK = 1'b0, RST_X = 1'b0;
    logic        BIT_IN = 1'b0, BIT_VALID = 1'b0, RNG_GO = 1'b0, RNG_STOP = 1'b0;
    logic        AXIS_RNG_TREADY = 1'b0;
    logic [31:0] RNG_SEND_BYTES = '0;
    logic        RNG_RUN, RNG_OVER, AXIS_RNG_TLAST, AXIS_RNG_TVALID;
    logic [31:0] RNG_SENT_BYTES, RNG_SUM_DATA, AXIS_RNG_TDATA;

    rng_stream_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_X(RST_X), .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID),
        .RNG_GO(RNG_GO), .RNG_STOP(RNG_STOP), .RNG_SEND_BYTES(RNG_SEND_BYTES),
        .RNG_RUN(RNG_RUN), .RNG_OVER(RNG_OVER), .RNG_SENT_BYTES(RNG_SENT_BYTES),
        .RNG_SUM_DATA(RNG_SUM_DATA), .AXIS_RNG_TDATA(AXIS_RNG_TDATA),
        .AXIS_RNG_TLAST(AXIS_RNG_TLAST), .AXIS_RNG_TVALID(AXIS_RNG_TVALID),
        .AXIS_RNG_TREADY(AXIS_RNG_TREADY)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] d; logic l; } ent_t;
    ent_t        mq[$];
    int          m_st, m_nb, m_target, m_pushed;
    logic [31:0] m_cur, m_sent, m_sum;
    logic        m_over;
    logic [31:0] got_d[$];
    logic        got_l[$];
    logic        hold, hold_l;
    logic [31:0] hold_d;
    int          checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_st = 0; m_nb = 0; m_target = 0; m_pushed = 0;
        m_cur = '0; m_sent = '0; m_sum = '0; m_over = 1'b0;
        hold = 1'b0;
    endtask

    task automatic check_outputs();
        logic v;
        v = mq.size() != 0;
        chk("tvalid", AXIS_RNG_TVALID, v);
        chk("tdata", AXIS_RNG_TDATA, v ? mq[0].d : 32'd0);
        chk("tlast", AXIS_RNG_TLAST, v ? mq[0].l : 1'b0);
        chk("run", RNG_RUN, m_st != 0);
        chk("over", RNG_OVER, m_over);
        chk("sent", RNG_SENT_BYTES, m_sent);
        chk("sum", RNG_SUM_DATA, m_sum);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_run"}, RNG_RUN, 0);
        chk({tag, "_over"}, RNG_OVER, 0);
        chk({tag, "_sent"}, RNG_SENT_BYTES, 0);
        chk({tag, "_sum"}, RNG_SUM_DATA, 0);
        chk({tag, "_tvalid"}, AXIS_RNG_TVALID, 0);
        chk({tag, "_tlast"}, AXIS_RNG_TLAST, 0);
        chk({tag, "_tdata"}, AXIS_RNG_TDATA, 0);
    endtask

    task automatic model_step(input logic bv, input logic b, input logic go, input logic stop, input logic rdy);
        int   sz;
        logic pushed_now;
        ent_t e;
        sz = mq.size();
        pushed_now = 1'b0;
        e.d = '0; e.l = 1'b0;
        if (m_st == 0) begin
            if (go) begin
                m_target = int'(RNG_SEND_BYTES[31:2]);
                m_pushed = 0; m_nb = 0; m_sent = '0; m_sum = '0; m_over = 1'b0; m_st = 1;
            end
        end else if (m_st == 1) begin
            if (bv) begin
                m_cur = {m_cur[30:0], b};
                m_nb++;
                if (m_nb == 32) begin
                    m_nb = 0;
                    if (sz < DEPTH) begin
                        m_pushed++;
                        pushed_now = 1'b1;
                        e.d = m_cur;
                        e.l = stop || (m_target != 0 && m_pushed == m_target);
                    end else m_over = 1'b1;
                end
            end
            if (stop) begin
                if (!pushed_now && sz != 0) mq[sz-1].l = 1'b1;
                m_st = (pushed_now || sz != 0) ? 2 : 0;
            end else if (pushed_now && e.l) m_st = 2;
        end else if (sz == 0) m_st = 0;
        if (sz != 0 && rdy) begin
            m_sent += 32'd4;
            m_sum += 32'($countones(mq[0].d));
            void'(mq.pop_front());
        end
        if (pushed_now) mq.push_back(e);
    endtask

    task automatic tick(input logic bv, input logic b, input logic go, input logic stop, input logic rdy);
        BIT_VALID = bv; BIT_IN = b; RNG_GO = go; RNG_STOP = stop; AXIS_RNG_TREADY = rdy;
        check_outputs();
        if (hold) begin
            chk("hold_tdata", AXIS_RNG_TDATA, hold_d);
            chk("hold_tlast", AXIS_RNG_TLAST, hold_l);
        end
        hold = AXIS_RNG_TVALID && !rdy;
        hold_d = AXIS_RNG_TDATA;
        hold_l = AXIS_RNG_TLAST;
        if (AXIS_RNG_TVALID && rdy) begin
            got_d.push_back(AXIS_RNG_TDATA);
            got_l.push_back(AXIS_RNG_TLAST);
        end
        model_step(bv, b, go, stop, rdy);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic start_run(input logic [31:0] bytes);
        RNG_SEND_BYTES = bytes;
        got_d.delete();
        got_l.delete();
        tick(0, 0, 1, 0, 1);
    endtask

    task automatic run_to_idle(input bit rnd_valid, input int rdy_mode);
        int k;
        k = 0;
        while (m_st != 0 && k < 4000) begin
            tick(rnd_valid ? ($urandom % 4 != 0) : 1'b1, 1'($urandom), 0, 0,
                 rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom) : 1'(k % 2));
            k++;
        end
        chk("idle_bound", k < 4000, 1);
        tick(0, 0, 0, 0, 1);
        chk("run_end", RNG_RUN, 0);
    endtask

    function automatic int n_last();
        int n;
        n = 0;
        foreach (got_l[i]) n += int'(got_l[i]);
        return n;
    endfunction

    task automatic reset_mid();
        BIT_VALID = 0; RNG_GO = 0; RNG_STOP = 0; AXIS_RNG_TREADY = 0;
        #2 RST_X = 1'b0;
        #1 check_zero("rst_mid");
        model_clear();
        @(negedge CLK);
        @(negedge CLK);
        RST_X = 1'b1;
    endtask

    initial begin
        model_clear();
        @(negedge CLK);
        @(negedge CLK);
        check_zero("rst");
        RST_X = 1'b1;
        tick(1, 1, 0, 1, 1);
        chk("stop_in_idle", RNG_RUN, 0);

        // two alternating-bit words, target reached on the second
        start_run(32'd8);
        for (int i = 0; i < 80; i++) tick(1, 1'(i % 2 == 0), 0, 0, 1);
        run_to_idle(0, 0);
        chk("s1_words", got_d.size(), 2);
        if (got_d.size() == 2) begin
            chk("s1_w0", got_d[0], 32'hAAAA_AAAA);
            chk("s1_w1", got_d[1], 32'hAAAA_AAAA);
            chk("s1_last1", got_l[1], 1);
        end
        chk("s1_nlast", n_last(), 1);
        chk("s1_sent", RNG_SENT_BYTES, 8);
        chk("s1_sum", RNG_SUM_DATA, 32);

        // overrun with stalled downstream, then completion of 16 words
        start_run(32'd64);
        for (int i = 0; i < 200; i++) tick(1, 1'($urandom), 0, 0, 0);
        chk("s2_over", RNG_OVER, 1);
        chk("s2_full_valid", AXIS_RNG_TVALID, 1);
        tick(1, 1, 1, 0, 0);
        run_to_idle(0, 0);
        chk("s2_words", got_d.size(), 16);
        chk("s2_nlast", n_last(), 1);
        chk("s2_sent", RNG_SENT_BYTES, 64);
        chk("s2_over_sticky", RNG_OVER, 1);

        // unlimited run stopped after 80 bits with words still buffered
        start_run(32'd0);
        for (int i = 0; i < 80; i++) tick(1, 1'($urandom), 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        run_to_idle(0, 0);
        chk("s3_words", got_d.size(), 2);
        if (got_l.size() == 2) chk("s3_last1", got_l[1], 1);
        chk("s3_sent", RNG_SENT_BYTES, 8);

        // stop with an empty buffer goes straight back to idle
        start_run(32'd0);
        for (int i = 0; i < 10; i++) tick(1, 1'($urandom), 0, 0, 1);
        tick(0, 0, 0, 1, 1);
        chk("s4_run", RNG_RUN, 0);
        chk("s4_tvalid", AXIS_RNG_TVALID, 0);
        tick(0, 0, 0, 0, 1);

        // stop on the word-completing bit pushes that word as last
        start_run(32'd0);
        for (int i = 0; i < 31; i++) tick(1, 1'($urandom), 0, 0, 1);
        tick(1, 1, 0, 1, 1);
        run_to_idle(0, 0);
        chk("s6_words", got_d.size(), 1);
        chk("s6_nlast", n_last(), 1);

        // toggling ready: outputs must hold under backpressure
        start_run(32'd16);
        run_to_idle(1, 2);
        chk("s5_words", got_d.size(), 4);
        chk("s5_nlast", n_last(), 1);
        chk("s5_sent", RNG_SENT_BYTES, 16);

        // reset during drain with three words buffered, then a fresh one-word run
        start_run(32'd0);
        for (int i = 0; i < 96; i++) tick(1, 1'($urandom), 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        chk("s7_draining", RNG_RUN, 1);
        reset_mid();
        tick(0, 0, 0, 0, 1);
        start_run(32'd4);
        run_to_idle(1, 0);
        chk("s7_words", got_d.size(), 1);
        if (got_l.size() == 1) chk("s7_last", got_l[0], 1);
        chk("s7_sent", RNG_SENT_BYTES, 4);

        // randomized lengths, valid and ready patterns
        for (int r = 0; r < 4; r++) begin
            start_run(32'($urandom_range(1, 10) * 4 + $urandom_range(0, 3)));
            run_to_idle(1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
